reg_file_master: RTL

// Initiator for the 16x8 register-file port (WrData/Address/RdEn/WrEn -> RdData).

---
 rtl/rf_master_pkg.sv | 36 +++
 rtl/reg_file_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_master_pkg.sv
// -----------------------------------------------------------------------------
// rf_master_pkg
// Shared definitions for the register-file initiator (reg_file_master) and the
// benches that exercise the register file:
//   - default data/address widths of the register-file port
//   - command opcode encodings carried on cmd_op
//   - the initiator FSM state type
// -----------------------------------------------------------------------------
package rf_master_pkg;

    // Default geometry of the register-file port: 16-bit data, 8 registers.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Command opcodes on cmd_op.
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    // IDLE : waiting for a command (cmd_ready high)
    // WR   : one-cycle write of the command data
    // RD   : one-cycle read strobe
    // CAP  : register file returns RdData; capture it (and form the RMW sum)
    // WB   : one-cycle write-back of the RMW sum
    // RSP  : response offered until consumed
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WB   = 3'd4,
        RSP  = 3'd5
    } state_t;

endpackage

// File: rtl/reg_file_master.sv
// -----------------------------------------------------------------------------
// reg_file_master
// Initiator for the register-file port (WrData/Address/RdEn/WrEn -> RdData).
// Accepts one command at a time (WRITE, READ, READ-ADD-WRITE) on a valid/ready
// handshake, sequences the RdEn/WrEn strobes and returns one response per
// command on a second valid/ready handshake.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous reset, active low
//   cmd_valid   in   command present
//   cmd_ready   out  command accepted when cmd_valid && cmd_ready at CLK rise
//   cmd_op      in   0=WRITE 1=READ 2=RMW 3=illegal
//   cmd_addr    in   target register
//   cmd_data    in   write data (WRITE) or addend (RMW)
//   rsp_valid   out  response present, held until rsp_ready
//   rsp_ready   in   response consumed when rsp_valid && rsp_ready at CLK rise
//   rsp_data    out  WRITE: echo, READ: register value, RMW: value written
//   rsp_err     out  illegal opcode flag
//   rf_WrData   out  register file write data
//   rf_Address  out  register file address
//   rf_RdEn     out  register file read strobe
//   rf_WrEn     out  register file write strobe
//   rf_RdData   in   register file read data, valid the cycle after rf_RdEn
// -----------------------------------------------------------------------------
module reg_file_master
    import rf_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rf_WrData,
    output logic [ADDR_W-1:0] rf_Address,
    output logic              rf_RdEn,
    output logic              rf_WrEn,
    input  logic [DATA_W-1:0] rf_RdData
);

    // Modular add: the carry out of the top bit is discarded.
    function automatic logic [DATA_W-1:0] wrap_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    // Command fields latched at accept. The address is held in r_rf_Address,
    // which is loaded at accept and stays put for the whole command.
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_sum;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rf_WrData;
    logic [ADDR_W-1:0] r_rf_Address;
    logic              r_rf_RdEn;
    logic              r_rf_WrEn;

    logic              w_accept;
    logic              w_rsp_hs;
    logic [DATA_W-1:0] w_sum;
    logic              w_rsp_load;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_rsp_err_nxt;

    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;
    assign w_sum     = wrap_add(rf_RdData, r_data);

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign rf_WrData  = r_rf_WrData;
    assign rf_Address = r_rf_Address;
    assign rf_RdEn    = r_rf_RdEn;
    assign rf_WrEn    = r_rf_WrEn;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the response value loaded on entry to RSP.
    always_comb begin
        w_state_nxt    = r_state;
        w_rsp_load     = 1'b0;
        w_rsp_data_nxt = '0;
        w_rsp_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_WRITE: w_state_nxt = WR;
                        OP_READ,
                        OP_RMW:   w_state_nxt = RD;
                        default: begin
                            w_state_nxt   = RSP;
                            w_rsp_load    = 1'b1;
                            w_rsp_err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                w_state_nxt    = RSP;
                w_rsp_load     = 1'b1;
                w_rsp_data_nxt = r_data;
            end
            RD: begin
                w_state_nxt = CAP;
            end
            CAP: begin
                if (r_op == OP_RMW) begin
                    w_state_nxt = WB;
                end else begin
                    w_state_nxt    = RSP;
                    w_rsp_load     = 1'b1;
                    w_rsp_data_nxt = rf_RdData;
                end
            end
            WB: begin
                w_state_nxt    = RSP;
                w_rsp_load     = 1'b1;
                w_rsp_data_nxt = r_sum;
            end
            RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command latch and RMW sum. These never leave the block before being
    // copied into a reset register, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
        end
        if (r_state == CAP) begin
            r_sum <= w_sum;
        end
    end

    // Registered port outputs. Strobes are decoded from the next state so
    // that they line up exactly with the WR/RD/WB cycles. rsp_valid is
    // raised from the RSP state register, one cycle after entering RSP,
    // and drops on the handshake edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rf_WrEn    <= 1'b0;
            r_rf_RdEn    <= 1'b0;
            r_rf_Address <= '0;
            r_rf_WrData  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rf_WrEn   <= (w_state_nxt == WR) || (w_state_nxt == WB);
            r_rf_RdEn   <= (w_state_nxt == RD);
            r_rsp_valid <= (r_state == RSP) && !w_rsp_hs;
            if (w_accept) begin
                r_rf_Address <= cmd_addr;
            end
            if (w_accept && (cmd_op == OP_WRITE)) begin
                r_rf_WrData <= cmd_data;
            end else if ((r_state == CAP) && (r_op == OP_RMW)) begin
                r_rf_WrData <= w_sum;
            end
            if (w_rsp_load) begin
                r_rsp_data <= w_rsp_data_nxt;
                r_rsp_err  <= w_rsp_err_nxt;
            end
        end
    end

endmodule
